// File: rtl/aes_ks_sequencer.sv
// Control sequencer for the masked AES key schedule.
// It walks the expanded-key word index one word per accepted step, for
// AES-128/192/256, in forward or inverse order. It also drives the round-constant
// generator and the RotWord/SubWord enables of the key-schedule datapath.
module aes_ks_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode_192,
    input  logic       mode_256,
    input  logic       inverse,
    input  logic       step,
    output logic       busy,
    output logic       done,
    output logic [5:0] word_idx,
    output logic       rot_en,
    output logic       sub_en,
    output logic       last_word,
    output logic       rcon_rst,
    output logic       rcon_update,
    output logic       rcon_enable,
    output logic       rcon_mode_192,
    output logic       rcon_mode_256,
    output logic       rcon_inverse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic [5:0] idx;        // expanded-key word index i
    logic [2:0] phase;      // i mod Nk, tracked incrementally
    logic       lat_192;    // latched AES-192 (cleared when AES-256 wins)
    logic       lat_256;    // latched AES-256
    logic       lat_inv;    // latched inverse direction

    logic [5:0] nk;         // first computed word index (Nk)
    logic [5:0] iend;       // final word index
    logic [2:0] phase_max;  // Nk-1, the phase wrap point
    logic       in_run;
    logic       at_last;

    // Key-size constants derived from the latched mode
    always_comb begin
        nk        = 6'd4;
        iend      = 6'd43;
        phase_max = 3'd3;
        if (lat_256) begin
            nk        = 6'd8;
            iend      = 6'd59;
            phase_max = 3'd7;
        end else if (lat_192) begin
            nk        = 6'd6;
            iend      = 6'd51;
            phase_max = 3'd5;
        end
    end

    // The final word is the top index going forward and Nk going backward
    always_comb begin
        at_last = lat_inv ? (idx == nk) : (idx == iend);
    end

    // Sequencer state, counters and latched run configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 6'd0;
            phase   <= 3'd0;
            lat_192 <= 1'b0;
            lat_256 <= 1'b0;
            lat_inv <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_256 <= mode_256;
                        lat_192 <= mode_192 & ~mode_256;
                        lat_inv <= inverse;
                        state   <= INIT;
                    end
                end
                INIT: begin
                    // iend mod Nk is 3 for every key size, so inverse starts at phase 3
                    if (lat_inv) begin
                        idx   <= iend;
                        phase <= 3'd3;
                    end else begin
                        idx   <= nk;
                        phase <= 3'd0;
                    end
                    state <= RUN;
                end
                RUN: begin
                    if (step) begin
                        if (at_last) begin
                            // Counters stay put so indices never leave [Nk, iend]
                            state <= DONE;
                        end else if (lat_inv) begin
                            idx   <= idx - 6'd1;
                            phase <= (phase == 3'd0) ? phase_max : phase - 3'd1;
                        end else begin
                            idx   <= idx + 6'd1;
                            phase <= (phase == phase_max) ? 3'd0 : phase + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode; everything except rcon_rst is forced low while rst is high
    always_comb begin
        in_run        = (state == RUN) && !rst;
        busy          = ((state == INIT) || (state == RUN)) && !rst;
        done          = (state == DONE) && !rst;
        word_idx      = rst ? 6'd0 : idx;
        rot_en        = in_run && (phase == 3'd0);
        rcon_enable   = in_run && (phase == 3'd0);
        sub_en        = in_run && ((phase == 3'd0) || (lat_256 && (phase == 3'd4)));
        last_word     = in_run && at_last;
        rcon_update   = in_run && step && (phase == 3'd0);
        rcon_rst      = rst || (state == INIT);
        rcon_mode_192 = lat_192 && !rst;
        rcon_mode_256 = lat_256 && !rst;
        rcon_inverse  = lat_inv && !rst;
    end

endmodule
